// File: rtl/lia_readout_sched_if.sv
// Signal bundle between the lock-in channels, the CPU PIOs and the readout scheduler.
interface lia_readout_sched_if #(
  parameter int N_CH = 8,
  parameter int CH_W = 3,
  parameter int DW   = 16
);
  logic [N_CH*DW-1:0] lia_x_in;
  logic [N_CH*DW-1:0] lia_y_in;
  logic [N_CH-1:0]    lia_valid;
  logic               snap_req;
  logic [CH_W-1:0]    sel_ch;
  logic [DW-1:0]      lia_1_x_export;
  logic [DW-1:0]      lia_1_y_export;
  logic               snap_done;
  logic               snap_timeout;
  logic               busy;
  logic [CH_W-1:0]    cap_ch;
  logic [7:0]         cap_count;

  // Master side: lock-in channels and CPU request bits drive, status is read back.
  modport master (
    output lia_x_in, lia_y_in, lia_valid, snap_req, sel_ch,
    input  lia_1_x_export, lia_1_y_export, snap_done, snap_timeout,
           busy, cap_ch, cap_count
  );

  // Slave side: the scheduler itself.
  modport slave (
    input  lia_x_in, lia_y_in, lia_valid, snap_req, sel_ch,
    output lia_1_x_export, lia_1_y_export, snap_done, snap_timeout,
           busy, cap_ch, cap_count
  );
endinterface

// File: rtl/lia_readout_sched.sv
// Readout scheduler: on a rising snap_req, waits for the selected lock-in
// channel's next strobe and captures a coherent X/Y pair, with timeout guard.
module lia_readout_sched #(
  parameter int N_CH    = 8,
  parameter int CH_W    = 3,
  parameter int DW      = 16,
  parameter int TIMEOUT = 65536
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  lia_readout_sched_if.slave bus
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t          state_q, state_d;
  logic            req_dly_q, req_dly_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   x_q, x_d;
  logic [DW-1:0]   y_q, y_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            busy_q, busy_d;
  logic [CH_W-1:0] cap_ch_q, cap_ch_d;
  logic [7:0]      cap_count_q, cap_count_d;

  logic            rise;
  logic            sel_bad;
  logic            hit;

  // Request edge detect, channel range check and the strobe of the latched channel.
  always_comb begin
    rise    = bus.snap_req & ~req_dly_q;
    sel_bad = (32'(bus.sel_ch) >= N_CH);
    hit     = bus.lia_valid[cap_ch_q];
  end

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next-state logic; a strobe on the last WAIT cycle still counts as a capture.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rise) state_d = sel_bad ? HOLD : WAIT;
      WAIT: if (hit || timer_q == '0) state_d = HOLD;
      HOLD: if (!bus.snap_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status next values; everything holds unless the state logic acts.
  always_comb begin
    req_dly_d   = bus.snap_req;
    timer_d     = timer_q;
    x_d         = x_q;
    y_d         = y_q;
    done_d      = done_q;
    timeout_d   = timeout_q;
    cap_ch_d    = cap_ch_q;
    cap_count_d = cap_count_q;
    busy_d      = (state_d == WAIT);
    case (state_q)
      IDLE: begin
        if (rise) begin
          cap_ch_d  = bus.sel_ch;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          timer_d   = TW'(TIMEOUT - 1);
          if (sel_bad) begin
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (hit) begin
          x_d         = bus.lia_x_in[int'(cap_ch_q)*DW +: DW];
          y_d         = bus.lia_y_in[int'(cap_ch_q)*DW +: DW];
          done_d      = 1'b1;
          cap_count_d = cap_count_q + 8'd1;
        end else if (timer_q == '0) begin
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and status registers; the request delay resets high so a held request is not an edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      req_dly_q   <= 1'b1;
      timer_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      cap_ch_q    <= '0;
      cap_count_q <= '0;
    end else begin
      req_dly_q   <= req_dly_d;
      timer_q     <= timer_d;
      x_q         <= x_d;
      y_q         <= y_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      cap_ch_q    <= cap_ch_d;
      cap_count_q <= cap_count_d;
    end
  end

  assign bus.lia_1_x_export = x_q;
  assign bus.lia_1_y_export = y_q;
  assign bus.snap_done      = done_q;
  assign bus.snap_timeout   = timeout_q;
  assign bus.busy           = busy_q;
  assign bus.cap_ch         = cap_ch_q;
  assign bus.cap_count      = cap_count_q;

endmodule

// File: tb/tb_lia_readout_sched.sv
// Scoreboard bench for the lock-in readout scheduler.
module tb_lia_readout_sched;

  localparam int N_CH    = 8;
  localparam int CH_W    = 3;
  localparam int DW      = 16;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [DW-1:0]   x;
    logic [DW-1:0]   y;
    logic            tmo;
    logic [7:0]      cnt;
    logic [CH_W-1:0] ch;
  } exp_t;

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;

  exp_t          expQ[$];
  int            testsRun = 0;
  int            testsFailed = 0;
  logic [7:0]    expCount = 8'd0;
  logic [DW-1:0] lastX = '0;
  logic [DW-1:0] lastY = '0;
  int            busyCnt = 0;
  int            busySnap;

  lia_readout_sched_if #(.N_CH(N_CH), .CH_W(CH_W), .DW(DW)) bus ();

  lia_readout_sched #(.N_CH(N_CH), .CH_W(CH_W), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .bus          (bus)
  );

  // Free-running clock.
  always #5 clk_clk = ~clk_clk;

  // Counts sampled cycles with busy high, used to measure WAIT length.
  always @(negedge clk_clk) if (bus.busy === 1'b1) busyCnt <= busyCnt + 1;

  // Hard stop in case the run wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setChannel(input int k, input logic [DW-1:0] x, input logic [DW-1:0] y);
    bus.lia_x_in[k*DW +: DW] = x;
    bus.lia_y_in[k*DW +: DW] = y;
  endtask

  // Raises the request and waits (bounded) for busy.
  task automatic raiseReq(input logic [CH_W-1:0] ch);
    bit seen = 0;
    bus.sel_ch   = ch;
    bus.snap_req = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk_clk);
      if (bus.busy === 1'b1) seen = 1;
    end
    if (!seen) checkOutput("busy_wait", 32'(bus.busy), 32'd1);
  endtask

  // Issues one request, strobes mask after delay cycles of WAIT, and pushes the expected result.
  task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [N_CH-1:0] mask,
                               input int delay, input logic [DW-1:0] x, input logic [DW-1:0] y);
    exp_t e;
    raiseReq(ch);
    if (mask[ch] && delay <= TIMEOUT - 1) begin
      expCount = expCount + 8'd1;
      lastX = x;
      lastY = y;
      e.tmo = 1'b0;
    end else begin
      e.tmo = 1'b1;
    end
    e.x = lastX; e.y = lastY; e.cnt = expCount; e.ch = ch;
    expQ.push_back(e);
    repeat (delay) @(negedge clk_clk);
    for (int k = 0; k < N_CH; k++) setChannel(k, DW'($urandom), DW'($urandom));
    setChannel(int'(ch), x, y);
    bus.lia_valid = mask;
    @(negedge clk_clk);
    bus.lia_valid = '0;
  endtask

  // Waits (bounded) for done, pops the scoreboard and compares, then completes the handshake.
  task automatic collectResult(input string tag);
    bit seen = 0;
    exp_t e;
    for (int i = 0; i < TIMEOUT + 8 && !seen; i++) begin
      if (bus.snap_done === 1'b1) seen = 1;
      else @(negedge clk_clk);
    end
    if (expQ.size() == 0) begin
      checkOutput({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput({tag, "_done"}, 32'(bus.snap_done), 32'd1);
      if (seen) begin
        checkOutput({tag, "_x"}, 32'(bus.lia_1_x_export), 32'(e.x));
        checkOutput({tag, "_y"}, 32'(bus.lia_1_y_export), 32'(e.y));
        checkOutput({tag, "_tmo"}, 32'(bus.snap_timeout), 32'(e.tmo));
        checkOutput({tag, "_cnt"}, 32'(bus.cap_count), 32'(e.cnt));
        checkOutput({tag, "_ch"}, 32'(bus.cap_ch), 32'(e.ch));
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
      end
    end
    bus.snap_req = 1'b0;
    repeat (2) @(negedge clk_clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_x"}, 32'(bus.lia_1_x_export), 32'd0);
    checkOutput({tag, "_y"}, 32'(bus.lia_1_y_export), 32'd0);
    checkOutput({tag, "_done"}, 32'(bus.snap_done), 32'd0);
    checkOutput({tag, "_tmo"}, 32'(bus.snap_timeout), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_ch"}, 32'(bus.cap_ch), 32'd0);
    checkOutput({tag, "_cnt"}, 32'(bus.cap_count), 32'd0);
  endtask

  // Main sequence.
  initial begin
    logic [CH_W-1:0] ch;
    logic [N_CH-1:0] mask;
    exp_t e;

    bus.lia_x_in  = '0;
    bus.lia_y_in  = '0;
    bus.lia_valid = '0;
    bus.sel_ch    = '0;
    bus.snap_req  = 1'b1;

    // Request held high through reset must not start a capture.
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (5) @(negedge clk_clk);
    checkAllZero("held_req");
    bus.snap_req = 1'b0;
    @(negedge clk_clk);

    // Channel 5, strobe 10 cycles into WAIT.
    applyStimulus(3'd5, 8'h20, 10, 16'h1234, 16'hFEDC);
    collectResult("ch5");

    // Channel 2 with only channels 0 and 7 strobing: full timeout.
    busySnap = busyCnt;
    applyStimulus(3'd2, 8'h81, 5, 16'hAAAA, 16'h5555);
    collectResult("tmo");
    checkOutput("tmo_wait_len", 32'(busyCnt - busySnap), 32'(TIMEOUT));

    // Strobe on the final WAIT cycle still captures.
    busySnap = busyCnt;
    applyStimulus(3'd4, 8'h10, TIMEOUT - 1, 16'h0F0F, 16'hC3C3);
    collectResult("last_cycle");
    checkOutput("last_wait_len", 32'(busyCnt - busySnap), 32'(TIMEOUT));

    // Strobe one cycle too late: timeout already taken.
    applyStimulus(3'd1, 8'h02, TIMEOUT, 16'h7777, 16'h8888);
    collectResult("too_late");

    // Second rising edge during WAIT is ignored.
    raiseReq(3'd1);
    expCount = expCount + 8'd1;
    lastX = 16'hBEEF;
    lastY = 16'h0101;
    e.x = lastX; e.y = lastY; e.tmo = 1'b0; e.cnt = expCount; e.ch = 3'd1;
    expQ.push_back(e);
    bus.snap_req = 1'b0;
    @(negedge clk_clk);
    bus.sel_ch   = 3'd6;
    bus.snap_req = 1'b1;
    repeat (2) @(negedge clk_clk);
    checkOutput("reedge_ch", 32'(bus.cap_ch), 32'd1);
    checkOutput("reedge_busy", 32'(bus.busy), 32'd1);
    setChannel(6, 16'h6666, 16'h6666);
    setChannel(1, 16'hBEEF, 16'h0101);
    bus.lia_valid = 8'h02;
    @(negedge clk_clk);
    bus.lia_valid = '0;
    collectResult("reedge");

    // Random captures until the capture counter wraps to 0.
    do begin
      ch   = CH_W'($urandom_range(N_CH - 1, 0));
      mask = N_CH'($urandom) | (N_CH'(1) << ch);
      applyStimulus(ch, mask, int'($urandom_range(8, 0)), DW'($urandom), DW'($urandom));
      collectResult("wrap_loop");
    end while (expCount != 8'd0);
    checkOutput("wrap_cnt", 32'(bus.cap_count), 32'd0);

    // Reset in the middle of WAIT clears everything immediately.
    raiseReq(3'd3);
    repeat (3) @(negedge clk_clk);
    #2 reset_reset_n = 1'b0;
    #1 checkAllZero("mid_reset");
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    expCount = 8'd0;
    lastX = '0;
    lastY = '0;
    bus.snap_req = 1'b0;
    repeat (2) @(negedge clk_clk);
    applyStimulus(3'd3, 8'h08, 4, 16'h3C3C, 16'h9A9A);
    collectResult("after_reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
